// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// The optional grant lock is enabled by defining ARB_LOCK_EN.
package arb_pkg;

   localparam int ARB_MAX_N = 32;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic       found;
      logic [4:0] idx;
   } pick_t;

   // Reference round-robin pick: first set bit scanning ptr, ptr+1, ... modulo n.
   function automatic pick_t rr_pick(input logic [ARB_MAX_N-1:0] vec,
                                     input logic [4:0]           ptr,
                                     input int                   n);
      pick_t r;
      int    j;
      r = '0;
      for (int i = 0; i < ARB_MAX_N; i++) begin
         j = (int'(ptr) + i) % n;
         if (i < n && !r.found && vec[j]) begin
            r.found = 1'b1;
            r.idx   = 5'(j);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rr_pick_mask.sv
// Combinational round-robin picker: lowest set bit of (req & ~excl) at or
// after ptr, found via a double-width vector and a masked priority encoder.
module rr_pick_mask
   import arb_pkg::*;
#(
   parameter int N   = 4,
   parameter int IDW = $clog2(N)
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   input  logic [N-1:0]   excl,
   output logic           found,
   output logic [IDW-1:0] idx
);

   localparam int W2 = 2 * N;
   localparam int PW = $clog2(W2);

   logic [N-1:0]  cand;
   logic [W2-1:0] lo_mask;
   logic [W2-1:0] dbl;
   logic [PW-1:0] pos;

   assign cand    = req & ~excl;
   // Clearing bits below ptr in the low copy makes the upper copy supply the wrap-around.
   assign lo_mask = (W2'(1) << ptr) - W2'(1);
   assign dbl     = {cand, cand} & ~lo_mask;

   always_comb begin
      pos = '0;
      for (int i = W2 - 1; i >= 0; i--) begin
         if (dbl[i]) pos = PW'(i);
      end
   end

   assign found = |cand;
   assign idx   = (pos >= PW'(N)) ? IDW'(pos - PW'(N)) : IDW'(pos);

endmodule

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter with grant hold and MAX_HOLD-bounded ownership.
// Define ARB_LOCK_EN to add the lock input that suppresses preemption.
module rr_arbiter
   import arb_pkg::*;
#(
   parameter int N        = 4,
   parameter int MAX_HOLD = 16,
   parameter int IDW      = $clog2(N)
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   output logic [N-1:0]   gnt,
   output logic           gnt_valid,
   output logic [IDW-1:0] gnt_id
`ifdef ARB_LOCK_EN
   ,
   input  logic           lock
`endif
);

   localparam int             HCW  = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
   localparam logic [HCW-1:0] HLIM = HCW'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
   localparam logic [IDW-1:0] LAST = IDW'(N - 1);

   arb_state_e     state, state_n;
   logic [IDW-1:0] ptr, ptr_n;
   logic [HCW-1:0] hcnt, hcnt_n;
   logic [N-1:0]   gnt_n;
   logic [IDW-1:0] id_n;
   logic [N-1:0]   excl;
   logic           found;
   logic [IDW-1:0] pick_idx;
   logic           own_req;
   logic           locked;
   logic           at_limit;
   logic           take;

`ifdef ARB_LOCK_EN
   assign locked = lock;
`else
   assign locked = 1'b0;
`endif

   // The current owner is masked so release and preemption both hand off to someone else.
   assign excl     = (state == GRANT) ? gnt : '0;
   assign own_req  = req[gnt_id];
   assign at_limit = (MAX_HOLD != 0) && (hcnt == HLIM);

   rr_pick_mask #(
      .N   (N),
      .IDW (IDW)
   ) u_pick (
      .req   (req),
      .ptr   (ptr),
      .excl  (excl),
      .found (found),
      .idx   (pick_idx)
   );

   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      hcnt_n  = hcnt;
      gnt_n   = gnt;
      id_n    = gnt_id;
      take    = 1'b0;
      case (state)
         IDLE: begin
            if (found) take = 1'b1;
         end
         GRANT: begin
            if (!own_req) begin
               if (found) begin
                  take = 1'b1;
               end else begin
                  state_n = IDLE;
                  gnt_n   = '0;
                  id_n    = '0;
                  hcnt_n  = '0;
               end
            end else if (at_limit && found && !locked) begin
               take = 1'b1;
            end else if (!locked && (MAX_HOLD != 0) && !at_limit) begin
               hcnt_n = hcnt + 1'b1;
            end
         end
      endcase
      if (take) begin
         state_n = GRANT;
         gnt_n   = N'(1) << pick_idx;
         id_n    = pick_idx;
         ptr_n   = (pick_idx == LAST) ? '0 : pick_idx + 1'b1;
         hcnt_n  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ptr    <= '0;
         hcnt   <= '0;
         gnt    <= '0;
         gnt_id <= '0;
      end else begin
         state  <= state_n;
         ptr    <= ptr_n;
         hcnt   <= hcnt_n;
         gnt    <= gnt_n;
         gnt_id <= id_n;
      end
   end

   assign gnt_valid = |gnt;

endmodule

// File: tb/tb_rr_arbiter.sv
// Directed bench for rr_arbiter: a vector table on a MAX_HOLD=4 instance plus
// short sequences for rotation, N=5 wrap-around and (with ARB_LOCK_EN) lock.
module tb_rr_arbiter;

   logic       clk;
   logic       rst;
   logic       lock;
   logic [3:0] r4, r1, r2;
   logic [4:0] r5;
   logic [3:0] g4, g1, g2;
   logic [4:0] g5;
   logic       v4, v1, v2, v5;
   logic [1:0] i4, i1, i2;
   logic [2:0] i5;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       rst;
      logic [3:0] req;
      logic [3:0] gnt;
      logic [1:0] id;
   } vec_t;

   vec_t tbl[$];

   rr_arbiter #(.N(4), .MAX_HOLD(4)) u4 (
      .clk(clk), .rst(rst), .req(r4), .gnt(g4), .gnt_valid(v4), .gnt_id(i4)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );

   rr_arbiter #(.N(4), .MAX_HOLD(1)) u1 (
      .clk(clk), .rst(rst), .req(r1), .gnt(g1), .gnt_valid(v1), .gnt_id(i1)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );

   rr_arbiter #(.N(4), .MAX_HOLD(2)) u2 (
      .clk(clk), .rst(rst), .req(r2), .gnt(g2), .gnt_valid(v2), .gnt_id(i2)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );

   rr_arbiter #(.N(5), .MAX_HOLD(16)) u5 (
      .clk(clk), .rst(rst), .req(r5), .gnt(g5), .gnt_valid(v5), .gnt_id(i5)
`ifdef ARB_LOCK_EN
      , .lock(lock)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic r, input logic [3:0] q, input logic [3:0] g, input logic [1:0] id);
      vec_t v;
      v.rst = r; v.req = q; v.gnt = g; v.id = id;
      tbl.push_back(v);
   endtask

   task automatic check4(input string tag, input logic [3:0] g, input logic [1:0] id);
      check({tag, " gnt"}, 32'(g4), 32'(g));
      check({tag, " valid"}, 32'(v4), 32'(g != 4'b0));
      check({tag, " id"}, 32'(i4), 32'(id));
   endtask

   initial begin
      logic [3:0] rot [5];
      rst = 1'b1; lock = 1'b0;
      r4 = '0; r1 = '0; r2 = '0; r5 = '0;
      tick(); tick();
      rst = 1'b0;
      check4("reset", 4'b0000, 2'd0);
      check("reset u5 gnt", 32'(g5), 32'h0);

      // Entry fields: rst, req, expected gnt, expected id
      add(0, 4'b1010, 4'b0010, 2'd1);
      add(0, 4'b1010, 4'b0010, 2'd1);
      add(0, 4'b0101, 4'b0100, 2'd2);
      add(0, 4'b0000, 4'b0000, 2'd0);
      add(0, 4'b0001, 4'b0001, 2'd0);
      for (int k = 0; k < 10; k++) add(0, 4'b0001, 4'b0001, 2'd0);
      add(0, 4'b1001, 4'b1000, 2'd3);
      add(0, 4'b0000, 4'b0000, 2'd0);
      for (int k = 0; k < 4; k++) add(0, 4'b1001, 4'b0001, 2'd0);
      add(0, 4'b1001, 4'b1000, 2'd3);
      add(0, 4'b1001, 4'b1000, 2'd3);
      add(0, 4'b0001, 4'b0001, 2'd0);
      add(0, 4'b0100, 4'b0100, 2'd2);
      add(1, 4'b1010, 4'b0000, 2'd0);
      add(0, 4'b1010, 4'b0010, 2'd1);
      add(0, 4'b0110, 4'b0010, 2'd1);
      add(0, 4'b0010, 4'b0010, 2'd1);
      add(0, 4'b0000, 4'b0000, 2'd0);

      for (int k = 0; k < tbl.size(); k++) begin
         rst = tbl[k].rst;
         r4  = tbl[k].req;
         tick();
         check4($sformatf("vec%0d", k), tbl[k].gnt, tbl[k].id);
      end
      rst = 1'b0;
      r4  = '0;

      // Per-cycle rotation with MAX_HOLD=1
      rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;
      r1 = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         tick();
         check($sformatf("rot%0d gnt", k), 32'(g1), 32'(rot[k]));
         check($sformatf("rot%0d valid", k), 32'(v1), 32'h1);
      end
      r1 = 4'b0000;
      tick();
      check("rot idle gnt", 32'(g1), 32'h0);

      // N=5 wrap-around from ptr=1
      r5 = 5'b00001; tick();
      check("n5 first gnt", 32'(g5), 32'h01);
      r5 = 5'b00000; tick();
      check("n5 idle gnt", 32'(g5), 32'h00);
      r5 = 5'b10001; tick();
      check("n5 wrap gnt", 32'(g5), 32'h10);
      check("n5 wrap id", 32'(i5), 32'd4);
      r5 = 5'b00001; tick();
      check("n5 handoff gnt", 32'(g5), 32'h01);
      check("n5 handoff id", 32'(i5), 32'd0);
      check("n5 handoff valid", 32'(v5), 32'h1);
      r5 = 5'b00000;

`ifdef ARB_LOCK_EN
      // Lock suppresses preemption once the hold limit is reached
      r2 = 4'b0011; lock = 1'b0;
      tick();
      check("lock grant", 32'(g2), 32'h1);
      tick();
      check("lock hold", 32'(g2), 32'h1);
      lock = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
         check($sformatf("lock held%0d", k), 32'(g2), 32'h1);
      end
      lock = 1'b0;
      tick();
      check("lock drop", 32'(g2), 32'h2);
      r2 = 4'b0000;
`endif
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Parametrised N-way round-robin arbiter with grant hold and a bounded hold time.
- Successor to the fixed-priority 4-request arbiter. It adds fair rotation, ownership that persists while the owner keeps requesting, and preemption after MAX_HOLD cycles.
- Sits in front of any shared resource: bus, memory port or shared datapath.

Parameters:
- N, 4: number of requesters; legal range 2..32.
- MAX_HOLD, 16: maximum consecutive grant cycles before preemption when others are waiting; 0 = unlimited.
- IDW, $clog2(N): width of gnt_id; derived, do not override.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req  in  N  request vector; bit i = requester i.
- gnt  out  N  registered one-hot grant; all zeros when idle.
- gnt_valid  out  1  high when gnt is non-zero.
- gnt_id  out  IDW  index of the current owner; 0 when idle.
- lock  in  1  present only with ARB_LOCK_EN; owner asserts it to suppress preemption.

Behaviour:
- Reset (rst=1 at posedge):
  - gnt=0, gnt_valid=0, gnt_id=0.
  - State returns to IDLE, rr pointer ptr=0, hold counter hcnt=0.
  - Reset mid-grant drops the grant on the next edge unconditionally.
- States: IDLE, GRANT.
- Pick function: first set bit of the candidate vector scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1, with wrap-around modulo N.
- IDLE:
  - If req != 0, the picked index w gets gnt=onehot(w) on the next edge. Latency is 1 cycle.
  - On that edge: ptr <= (w+1) mod N, hcnt <= 0, state goes to GRANT.
  - If req == 0, outputs stay zero.
- GRANT, owner o:
  - If req[o]=1 and no preemption: hold gnt; hcnt increments and saturates at MAX_HOLD-1.
  - If req[o]=0 (owner releases): pick among req with bit o masked.
    - If a requester is picked, grant it on the next edge with no idle bubble.
    - Otherwise go to IDLE with gnt=0.
  - Preemption fires when MAX_HOLD != 0, hcnt == MAX_HOLD-1, req[o]=1 and any other req bit is set.
    - The next edge grants pick(req with bit o masked).
    - The preempted owner rejoins rotation and is next eligible only after the pointer passes it.
  - If hcnt reaches its limit with no other requester: keep the grant and hold hcnt at MAX_HOLD-1. Preemption fires as soon as another request appears.
- Every new grant (from IDLE, handoff or preemption) sets hcnt=0 and ptr=(new owner+1) mod N.
- gnt is always one-hot or zero; never multi-hot.
- gnt_valid == |gnt; gnt_id == index of the set bit.
- Simultaneous owner release and new requests: handled in the same cycle as the release path.
- Requests that appear and drop while another requester owns the grant are not remembered. There is no queuing.
- MAX_HOLD=1: preempts every cycle when contended, which gives pure per-cycle round-robin.

Optional Feature:
- Macro: ARB_LOCK_EN.
- Defined:
  - Adds the lock input.
  - While gnt_valid=1 and lock=1, preemption is suppressed and hcnt holds its value.
  - Release by dropping req is still honoured.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - Preemption is governed only by MAX_HOLD.

Decomposition:
- Package arb_pkg:
  - arb_state_e enum {IDLE, GRANT}.
  - Function rr_pick(vec, ptr) returning the index plus a found flag.
  - Constant ARB_MAX_N=32.
- Sub-module rr_pick_mask, combinational:
  - Inputs req, ptr, exclude-mask.
  - Outputs found and idx.
  - Implementation: double-width vector with a masked priority encoder.
- Top level holds the FSM, ptr, hcnt and output registers.

Test Plan:
1. Reset and idle: assert rst mid-grant (owner 2) -> next edge gnt=0, gnt_valid=0, gnt_id=0; then req=4'b1010 with ptr=0 -> gnt=4'b0010 one cycle later.
2. Rotation: N=4, MAX_HOLD=1, req=4'b1111 held -> gnt sequence 0001, 0010, 0100, 1000, 0001, with gnt_valid continuously high.
3. Hold and preempt: MAX_HOLD=4; req[0] held alone for 10 cycles -> gnt=0001 throughout; raise req[3] -> gnt switches to 1000 on the next edge (hcnt saturated). Repeat with req[3] present from the start -> switch after exactly 4 grant cycles.
4. Release handoff: owner 1 drops req while req[2] and req[0] are set -> next edge gnt=0100 (no bubble); then all req=0 -> gnt=0, state IDLE.
5. Lock (ARB_LOCK_EN): MAX_HOLD=2, owner 0 with lock=1, req=4'b0011 for 8 cycles -> gnt stays 0001; drop lock -> gnt=0010 on the next edge.
6. Wrap-around: ptr=3 (last grant to 2), req=4'b0001 -> gnt=0001; N=5 parameter run with req=5'b10001 and ptr=1 -> grants index 4, then 0.
